trace_uart_dump: RTL

Writeback-trace dumper that sits directly downstream of the SoC's `debug_wb_*` outputs. It captures one record per retired instruction into a small FIFO and streams each record out as a fixed 10-byte packet over an 8N1 UART transmit line. This lets the board-level trace be compared against the golden simulator trace without a logic analyser. Records that arrive while the FIFO is full are dropped and counted; they never stall the core.

---
 rtl/trace_uart_dump.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/trace_uart_dump.sv
// Writeback-trace dumper: buffers retired-instruction records in a FIFO and
// streams each one as a 10-byte 8N1 UART packet (A5, pc, {ena,00,reg}, value).
module trace_uart_dump #(
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        debug_wb_have_inst,
  input  logic [31:0] debug_wb_pc,
  input  logic        debug_wb_ena,
  input  logic [4:0]  debug_wb_reg,
  input  logic [31:0] debug_wb_value,
  output logic        uart_txd,
  output logic        busy,
  output logic        overflow,
  output logic [15:0] drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TMR_LOAD = TW'(CLKS_PER_BIT - 1);

  // state | meaning: IDLE wait/pop | LOAD reset indices | START start bit | DATA data bits | STOP stop bit
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [69:0]   mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, pop, push_ok, drop;

  logic [2:0]    state;
  logic [69:0]   rec;
  logic [3:0]    byte_idx;
  logic [2:0]    bit_idx;
  logic [TW-1:0] tmr;
  logic [7:0]    tx_byte;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = (state == S_IDLE) && !empty;
  assign push_ok = debug_wb_have_inst && (!full || pop);
  assign drop    = debug_wb_have_inst && full && !pop;
  assign busy    = !empty || (state != S_IDLE);

  function automatic logic [7:0] byte_sel(input logic [69:0] r, input logic [3:0] idx);
    case (idx)
      4'd0:    byte_sel = 8'hA5;
      4'd1:    byte_sel = r[69:62];
      4'd2:    byte_sel = r[61:54];
      4'd3:    byte_sel = r[53:46];
      4'd4:    byte_sel = r[45:38];
      4'd5:    byte_sel = {r[37], 2'b00, r[36:32]};
      4'd6:    byte_sel = r[31:24];
      4'd7:    byte_sel = r[23:16];
      4'd8:    byte_sel = r[15:8];
      default: byte_sel = r[7:0];
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr[AW-1:0]] <= {debug_wb_pc, debug_wb_ena, debug_wb_reg, debug_wb_value};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // txd is assigned alongside each state transition so the line is a clean flop output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rec      <= '0;
      byte_idx <= '0;
      bit_idx  <= '0;
      tmr      <= '0;
      tx_byte  <= '0;
      uart_txd <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          uart_txd <= 1'b1;
          if (!empty) begin
            rec   <= mem[rd_ptr[AW-1:0]];
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          byte_idx <= 4'd0;
          bit_idx  <= 3'd0;
          tmr      <= TMR_LOAD;
          tx_byte  <= byte_sel(rec, 4'd0);
          uart_txd <= 1'b0;
          state    <= S_START;
        end
        S_START: begin
          if (tmr == '0) begin
            tmr      <= TMR_LOAD;
            bit_idx  <= 3'd0;
            uart_txd <= tx_byte[0];
            state    <= S_DATA;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_DATA: begin
          if (tmr == '0) begin
            tmr     <= TMR_LOAD;
            tx_byte <= {1'b0, tx_byte[7:1]};
            if (bit_idx == 3'd7) begin
              uart_txd <= 1'b1;
              state    <= S_STOP;
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              uart_txd <= tx_byte[1];
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_STOP: begin
          if (tmr == '0) begin
            if (byte_idx == 4'd9) begin
              state <= S_IDLE;
            end else begin
              byte_idx <= byte_idx + 4'd1;
              tx_byte  <= byte_sel(rec, byte_idx + 4'd1);
              tmr      <= TMR_LOAD;
              uart_txd <= 1'b0;
              state    <= S_START;
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: begin
          uart_txd <= 1'b1;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
